fastica_iter_ctrl: RTL and testbench

- Iteration sequencer for the FastICA weight-update loop.
- Per iteration: loads the 4x4 W matrix, starts the update stage, then the normalise stage, then strobes the error/convergence stage (en_out) and samples its registered convergence flag.
- Stops on convergence, on the iteration limit, on abort, or on a per-stage watchdog timeout. Reports status to the top-level host FSM.

---
 rtl/fastica_iter_ctrl_pkg.sv | 22 ++
 rtl/fastica_iter_ctrl_stage_watchdog.sv | 36 +++
 rtl/fastica_iter_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fastica_iter_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fastica_iter_ctrl_pkg.sv
// Shared definitions for the FastICA iteration sequencer: state codes and
// default sizing constants.
package fastica_ctrl_pkg;

   localparam int ITER_W    = 8;
   localparam int MAX_ITER  = 100;
   localparam int TMO_W     = 10;
   localparam int TMO_LIMIT = 1000;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      LOAD     = 4'd1,
      UPD_GO   = 4'd2,
      UPD_WAIT = 4'd3,
      NRM_GO   = 4'd4,
      NRM_WAIT = 4'd5,
      CHK_EN   = 4'd6,
      CHK_SMP  = 4'd7,
      DONE     = 4'd8
   } state_t;

endpackage

// File: rtl/fastica_iter_ctrl_stage_watchdog.sv
// Stage watchdog shared by the update and normalise WAIT states: cleared in
// the GO cycle, counts while waiting, flags expiry.
module stage_watchdog #(
   parameter int TMO_W     = fastica_ctrl_pkg::TMO_W,
   parameter int TMO_LIMIT = fastica_ctrl_pkg::TMO_LIMIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   import fastica_ctrl_pkg::*;

   // expire marks the cycle whose closing edge moves the count onto TMO_LIMIT-1,
   // so the owning FSM leaves exactly TMO_LIMIT cycles after the start strobe
   localparam logic [TMO_W-1:0] EXP_AT = TMO_W'(TMO_LIMIT - 2);

   logic [TMO_W-1:0] cnt_r;

   // wait-cycle counter, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (en && (cnt_r != {TMO_W{1'b1}})) begin
         cnt_r <= cnt_r + TMO_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = en && (cnt_r == EXP_AT);

endmodule

// File: rtl/fastica_iter_ctrl.sv
// FastICA iteration sequencer: load W, run update and normalise stages, strobe
// the convergence check, and stop on convergence, limit, abort or timeout.
module fastica_iter_ctrl #(
   parameter int ITER_W    = fastica_ctrl_pkg::ITER_W,
   parameter int MAX_ITER  = fastica_ctrl_pkg::MAX_ITER,
   parameter int CONV_HITS = 2,
   parameter int TMO_W     = fastica_ctrl_pkg::TMO_W,
   parameter int TMO_LIMIT = fastica_ctrl_pkg::TMO_LIMIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ITER_W-1:0] max_iter_cfg,
   output logic              upd_start,
   input  logic              upd_done,
   output logic              norm_start,
   input  logic              norm_done,
   output logic              en_out,
   input  logic              is_converge,
   output logic              w_sel,
   output logic              w_load,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic              err_timeout,
   output logic [ITER_W-1:0] iter_count
);
   import fastica_ctrl_pkg::*;

   state_t            state_r;
   logic [ITER_W-1:0] limit_r;
   logic [2:0]        hit_r;
   logic [ITER_W-1:0] iter_next_s;
   logic [2:0]        hit_next_s;
   logic              wd_clr_s;
   logic              wd_en_s;
   logic              wd_expire_s;

   // next-iteration bookkeeping and watchdog control
   always_comb begin
      iter_next_s = (iter_count == {ITER_W{1'b1}}) ? iter_count : iter_count + ITER_W'(1);
      hit_next_s  = is_converge ? (hit_r + 3'd1) : 3'd0;
      wd_clr_s    = (state_r == UPD_GO) || (state_r == NRM_GO);
      wd_en_s     = (state_r == UPD_WAIT) || (state_r == NRM_WAIT);
   end

   stage_watchdog #(
      .TMO_W     (TMO_W),
      .TMO_LIMIT (TMO_LIMIT)
   ) u_wd (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wd_clr_s),
      .en     (wd_en_s),
      .expire (wd_expire_s)
   );

   // sequencer FSM; each strobe is set on entry to the state it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         limit_r     <= {ITER_W{1'b0}};
         hit_r       <= 3'd0;
         iter_count  <= {ITER_W{1'b0}};
         upd_start   <= 1'b0;
         norm_start  <= 1'b0;
         en_out      <= 1'b0;
         w_load      <= 1'b0;
         w_sel       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         converged   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         w_load     <= 1'b0;
         upd_start  <= 1'b0;
         norm_start <= 1'b0;
         en_out     <= 1'b0;
         if (abort) begin
            state_r     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            err_timeout <= 1'b0;
         end else begin
            case (state_r)
               IDLE, DONE: begin
                  if (start) begin
                     limit_r     <= (max_iter_cfg == {ITER_W{1'b0}}) ? ITER_W'(MAX_ITER) : max_iter_cfg;
                     iter_count  <= {ITER_W{1'b0}};
                     hit_r       <= 3'd0;
                     converged   <= 1'b0;
                     err_timeout <= 1'b0;
                     done        <= 1'b0;
                     busy        <= 1'b1;
                     w_sel       <= 1'b0;
                     w_load      <= 1'b1;
                     state_r     <= LOAD;
                  end else begin
                     state_r <= state_r;
                  end
               end
               LOAD: begin
                  upd_start <= 1'b1;
                  state_r   <= UPD_GO;
               end
               UPD_GO: state_r <= UPD_WAIT;
               UPD_WAIT: begin
                  if (upd_done) begin
                     norm_start <= 1'b1;
                     state_r    <= NRM_GO;
                  end else if (wd_expire_s) begin
                     err_timeout <= 1'b1;
                     done        <= 1'b1;
                     busy        <= 1'b0;
                     state_r     <= DONE;
                  end else begin
                     state_r <= UPD_WAIT;
                  end
               end
               NRM_GO: state_r <= NRM_WAIT;
               NRM_WAIT: begin
                  if (norm_done) begin
                     en_out  <= 1'b1;
                     state_r <= CHK_EN;
                  end else if (wd_expire_s) begin
                     err_timeout <= 1'b1;
                     done        <= 1'b1;
                     busy        <= 1'b0;
                     state_r     <= DONE;
                  end else begin
                     state_r <= NRM_WAIT;
                  end
               end
               CHK_EN: state_r <= CHK_SMP;
               CHK_SMP: begin
                  iter_count <= iter_next_s;
                  hit_r      <= hit_next_s;
                  // convergence outranks the limit when both land together
                  if (hit_next_s >= 3'(CONV_HITS)) begin
                     converged <= 1'b1;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_r   <= DONE;
                  end else if (iter_next_s == limit_r) begin
                     converged <= 1'b0;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_r   <= DONE;
                  end else begin
                     w_sel   <= 1'b1;
                     w_load  <= 1'b1;
                     state_r <= LOAD;
                  end
               end
               default: begin
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fastica_iter_ctrl.sv
// Directed bench for fastica_iter_ctrl: convergence, limit, hit reset,
// timeout, abort/restart and coincident-event cases.
module tb_fastica_iter_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] max_iter_cfg;
   logic       upd_start;
   logic       upd_done;
   logic       norm_start;
   logic       norm_done;
   logic       en_out;
   logic       is_converge;
   logic       w_sel;
   logic       w_load;
   logic       busy;
   logic       done;
   logic       converged;
   logic       err_timeout;
   logic [7:0] iter_count;

   int n_pass  = 0;
   int n_total = 0;
   int en_cnt  = 0;
   int multi_hot = 0;
   int en_base;

   fastica_iter_ctrl #(
      .ITER_W    (8),
      .MAX_ITER  (100),
      .CONV_HITS (2),
      .TMO_W     (10),
      .TMO_LIMIT (1000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .max_iter_cfg (max_iter_cfg),
      .upd_start    (upd_start),
      .upd_done     (upd_done),
      .norm_start   (norm_start),
      .norm_done    (norm_done),
      .en_out       (en_out),
      .is_converge  (is_converge),
      .w_sel        (w_sel),
      .w_load       (w_load),
      .busy         (busy),
      .done         (done),
      .converged    (converged),
      .err_timeout  (err_timeout),
      .iter_count   (iter_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // strobe monitor: counts en_out pulses and any cycle with two strobes high
   always @(negedge clk) begin
      if (rst_n) begin
         en_cnt <= en_cnt + int'(en_out);
         if ((int'(w_load) + int'(upd_start) + int'(norm_start) + int'(en_out)) > 1)
            multi_hot <= multi_hot + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic start_run(input logic [7:0] cfg, input string tag);
      is_converge  = 1'b0;
      max_iter_cfg = cfg;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " start w_load"}, 32'(w_load), 32'd1);
      chk({tag, " start w_sel"}, 32'(w_sel), 32'd0);
      chk({tag, " start iter_count"}, 32'(iter_count), 32'd0);
      chk({tag, " start busy"}, 32'(busy), 32'd1);
   endtask

   // one full iteration starting in LOAD; ends in the state after CHK_SMP
   task automatic iter(input int tu, input int tn, input logic conv,
                       input logic exp_sel, input logic exp_end, input string tag);
      chk({tag, " w_load"}, 32'(w_load), 32'd1);
      chk({tag, " w_sel"}, 32'(w_sel), 32'(exp_sel));
      tick();
      chk({tag, " upd_start"}, 32'(upd_start), 32'd1);
      repeat (tu) tick();
      upd_done = 1'b1;
      tick();
      upd_done = 1'b0;
      chk({tag, " norm_start"}, 32'(norm_start), 32'd1);
      repeat (tn) tick();
      norm_done = 1'b1;
      tick();
      norm_done = 1'b0;
      chk({tag, " en_out"}, 32'(en_out), 32'd1);
      is_converge = conv;
      tick();
      tick();
      chk({tag, " done"}, 32'(done), 32'(exp_end));
      chk({tag, " next w_load"}, 32'(w_load), 32'(!exp_end));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; max_iter_cfg = 8'd0;
      upd_done = 1'b0; norm_done = 1'b0; is_converge = 1'b0;
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst iter_count", 32'(iter_count), 32'd0);
      chk("rst strobes", {28'd0, w_load, upd_start, norm_start, en_out}, 32'd0);
      chk("rst flags", {29'd0, w_sel, converged, err_timeout}, 32'd0);
      #13 rst_n = 1'b1;
      tick();
      chk("idle busy", 32'(busy), 32'd0);

      // nominal convergence: hits on iterations 4 and 5
      start_run(8'd0, "nom");
      iter(3, 3, 1'b0, 1'b0, 1'b0, "nom i1");
      iter(3, 3, 1'b0, 1'b1, 1'b0, "nom i2");
      iter(3, 3, 1'b0, 1'b1, 1'b0, "nom i3");
      iter(3, 3, 1'b1, 1'b1, 1'b0, "nom i4");
      iter(3, 3, 1'b1, 1'b1, 1'b1, "nom i5");
      chk("nom converged", 32'(converged), 32'd1);
      chk("nom iter_count", 32'(iter_count), 32'd5);
      chk("nom err_timeout", 32'(err_timeout), 32'd0);
      chk("nom busy", 32'(busy), 32'd0);
      tick();
      chk("nom hold done", 32'(done), 32'd1);
      chk("nom hold iter", 32'(iter_count), 32'd5);

      // iteration limit of 3, relaunched from DONE
      en_base = en_cnt;
      start_run(8'd3, "lim");
      chk("lim done cleared", 32'(done), 32'd0);
      chk("lim converged cleared", 32'(converged), 32'd0);
      iter(1, 2, 1'b0, 1'b0, 1'b0, "lim i1");
      iter(1, 2, 1'b0, 1'b1, 1'b0, "lim i2");
      iter(1, 2, 1'b0, 1'b1, 1'b1, "lim i3");
      chk("lim converged", 32'(converged), 32'd0);
      chk("lim iter_count", 32'(iter_count), 32'd3);
      tick();
      chk("lim en pulses", 32'(en_cnt - en_base), 32'd3);

      // hit counter restarts after a miss
      start_run(8'd0, "hit");
      iter(2, 1, 1'b1, 1'b0, 1'b0, "hit i1");
      iter(2, 1, 1'b0, 1'b1, 1'b0, "hit i2");
      iter(2, 1, 1'b1, 1'b1, 1'b0, "hit i3");
      iter(2, 1, 1'b1, 1'b1, 1'b1, "hit i4");
      chk("hit converged", 32'(converged), 32'd1);
      chk("hit iter_count", 32'(iter_count), 32'd4);

      // normalise stage never answers; a stray upd_done is injected meanwhile
      start_run(8'd0, "tmo");
      tick();
      chk("tmo upd_start", 32'(upd_start), 32'd1);
      tick();
      upd_done = 1'b1;
      tick();
      upd_done = 1'b0;
      chk("tmo norm_start", 32'(norm_start), 32'd1);
      en_base = en_cnt;
      repeat (500) tick();
      upd_done = 1'b1;
      tick();
      upd_done = 1'b0;
      repeat (498) tick();
      chk("tmo not yet done", 32'(done), 32'd0);
      chk("tmo still busy", 32'(busy), 32'd1);
      tick();
      chk("tmo done", 32'(done), 32'd1);
      chk("tmo err_timeout", 32'(err_timeout), 32'd1);
      chk("tmo converged", 32'(converged), 32'd0);
      chk("tmo iter_count", 32'(iter_count), 32'd0);
      chk("tmo no en_out", 32'(en_cnt - en_base), 32'd0);

      // abort during UPD_WAIT of iteration 2
      start_run(8'd0, "abt");
      chk("abt err cleared", 32'(err_timeout), 32'd0);
      iter(1, 1, 1'b0, 1'b0, 1'b0, "abt i1");
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abt busy", 32'(busy), 32'd0);
      chk("abt done", 32'(done), 32'd0);
      chk("abt iter_count", 32'(iter_count), 32'd1);
      chk("abt strobes", {28'd0, w_load, upd_start, norm_start, en_out}, 32'd0);
      norm_done = 1'b1;
      tick();
      norm_done = 1'b0;
      tick();
      chk("abt idle stays", {30'd0, busy, norm_start}, 32'd0);

      // restart after abort; upd_done lands on the watchdog expiry cycle
      start_run(8'd0, "coin");
      tick();
      chk("coin upd_start", 32'(upd_start), 32'd1);
      repeat (999) tick();
      upd_done = 1'b1;
      tick();
      upd_done = 1'b0;
      chk("coin norm_start", 32'(norm_start), 32'd1);
      chk("coin err_timeout", 32'(err_timeout), 32'd0);
      chk("coin done", 32'(done), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("coin abort busy", 32'(busy), 32'd0);

      // start and abort together: abort wins
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa busy", 32'(busy), 32'd0);
      chk("sa w_load", 32'(w_load), 32'd0);
      tick();
      chk("sa still idle", 32'(busy), 32'd0);

      // asynchronous reset while en_out is high
      start_run(8'd0, "rst");
      tick();
      tick();
      upd_done = 1'b1;
      tick();
      upd_done = 1'b0;
      tick();
      norm_done = 1'b1;
      tick();
      norm_done = 1'b0;
      chk("rst en_out before", 32'(en_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst en_out async", 32'(en_out), 32'd0);
      chk("rst busy async", 32'(busy), 32'd0);
      chk("rst iter async", 32'(iter_count), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      chk("rst idle after", {30'd0, busy, done}, 32'd0);

      chk("strobes never overlap", 32'(multi_hot), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
